// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants, immediate limits and the assembler state type
// shared by the instruction assembler and its packing logic.
package rv_isa_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // B-type offsets are byte offsets; bit 0 is implied zero in the encoding.
  localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
  localparam logic signed [31:0] IMMB_MIN  = -32'sd4096;
  localparam logic signed [31:0] IMMB_MAX  = 32'sd4094;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
    WRITE  = 2'd2
  } state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer: builds the 32-bit word for R/I/load/S/B
// formats and reports whether the opcode is supported and the immediate fits.
module instr_pack
  import rv_isa_pkg::*;
(
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        legal_o
);

  logic imm12_ok_s;
  logic immb_ok_s;

  assign imm12_ok_s = ($signed(imm_i) >= IMM12_MIN) && ($signed(imm_i) <= IMM12_MAX);
  assign immb_ok_s  = ($signed(imm_i) >= IMMB_MIN) && ($signed(imm_i) <= IMMB_MAX) &&
                      (imm_i[0] == 1'b0);

  always_comb begin
    word_o  = 32'h0000_0000;
    legal_o = 1'b0;
    case (opcode_i)
      OP_R: begin
        word_o  = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
        legal_o = 1'b1;
      end
      OP_IMM, OP_LOAD: begin
        word_o  = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        legal_o = imm12_ok_s;
      end
      OP_STORE: begin
        word_o  = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        legal_o = imm12_ok_s;
      end
      OP_BRANCH: begin
        word_o  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                   imm_i[4:1], imm_i[11], opcode_i};
        legal_o = immb_ok_s;
      end
      default: begin
        word_o  = 32'h0000_0000;
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_assembler.sv
// Field-level instruction assembler: captures a request, packs it into an RV32I
// word and writes it to instruction memory at an auto-incrementing address.
module instr_assembler
  import rv_isa_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [6:0]        req_opcode,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [2:0]        req_funct3,
  input  logic [6:0]        req_funct7,
  input  logic [31:0]       req_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic [ADDR_W:0]   word_count,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   CNT_MAX = {(ADDR_W+1){1'b1}};

  state_e            state_q, state_d;
  logic [6:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [2:0]        f3_q, f3_d;
  logic [6:0]        f7_q, f7_d;
  logic [31:0]       imm_q, imm_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  logic [31:0]       pack_word_s;
  logic              pack_legal_s;

  instr_pack u_pack (
    .opcode_i (op_q),
    .rd_i     (rd_q),
    .rs1_i    (rs1_q),
    .rs2_i    (rs2_q),
    .funct3_i (f3_q),
    .funct7_i (f7_q),
    .imm_i    (imm_q),
    .word_o   (pack_word_s),
    .legal_o  (pack_legal_s)
  );

  // Next-state and output-register logic; clr overrides every state.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    f3_d       = f3_q;
    f7_d       = f7_q;
    imm_d      = imm_q;
    ready_d    = ready_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    count_d    = count_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (clr) begin
      state_d    = IDLE;
      ready_d    = 1'b1;
      we_d       = 1'b0;
      wdata_d    = 32'h0000_0000;
      addr_d     = BASE;
      count_d    = {(ADDR_W+1){1'b0}};
      err_d      = 1'b0;
      err_addr_d = {ADDR_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            op_d    = req_opcode;
            rd_d    = req_rd;
            rs1_d   = req_rs1;
            rs2_d   = req_rs2;
            f3_d    = req_funct3;
            f7_d    = req_funct7;
            imm_d   = req_imm;
            ready_d = 1'b0;
            state_d = ENCODE;
          end else begin
            state_d = IDLE;
          end
        end
        ENCODE: begin
          if (pack_legal_s) begin
            wdata_d = pack_word_s;
            we_d    = 1'b1;
            state_d = WRITE;
          end else begin
            // Only the first violation records its address.
            if (!err_q) begin
              err_d      = 1'b1;
              err_addr_d = addr_q;
            end else begin
              err_d      = err_q;
            end
            ready_d = 1'b1;
            state_d = IDLE;
          end
        end
        WRITE: begin
          if (imem_ready) begin
            we_d    = 1'b0;
            ready_d = 1'b1;
            addr_d  = addr_q + ADDR_W'(1);
            if (count_q != CNT_MAX) begin
              count_d = count_q + (ADDR_W+1)'(1);
            end else begin
              count_d = count_q;
            end
            state_d = IDLE;
          end else begin
            state_d = WRITE;
          end
        end
        default: begin
          state_d = IDLE;
          ready_d = 1'b1;
          we_d    = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= 7'd0;
      rd_q       <= 5'd0;
      rs1_q      <= 5'd0;
      rs2_q      <= 5'd0;
      f3_q       <= 3'd0;
      f7_q       <= 7'd0;
      imm_q      <= 32'h0000_0000;
      ready_q    <= 1'b1;
      we_q       <= 1'b0;
      wdata_q    <= 32'h0000_0000;
      addr_q     <= BASE;
      count_q    <= {(ADDR_W+1){1'b0}};
      err_q      <= 1'b0;
      err_addr_q <= {ADDR_W{1'b0}};
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      f3_q       <= f3_d;
      f7_q       <= f7_d;
      imm_q      <= imm_d;
      ready_q    <= ready_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign req_ready  = ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign word_count = count_q;
  assign err        = err_q;
  assign err_addr   = err_addr_q;

endmodule

// File: tb/tb_instr_assembler.sv
// Bench: two assembler instances (default and ADDR_W=2/BASE_ADDR=1) share all
// inputs and are checked against a field-level reference model.
module tb_instr_assembler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        req_valid = 1'b0;
  logic [6:0]  req_opcode = 7'd0;
  logic [4:0]  req_rd = 5'd0, req_rs1 = 5'd0, req_rs2 = 5'd0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [6:0]  req_funct7 = 7'd0;
  logic [31:0] req_imm = 32'd0;
  logic        imem_ready = 1'b1;

  logic        a_req_ready, a_imem_we, a_err;
  logic [7:0]  a_imem_addr, a_err_addr;
  logic [31:0] a_imem_wdata;
  logic [8:0]  a_word_count;
  logic        b_req_ready, b_imem_we, b_err;
  logic [1:0]  b_imem_addr, b_err_addr;
  logic [31:0] b_imem_wdata;
  logic [2:0]  b_word_count;

  int vectors = 0;
  int miscompares = 0;

  int ma_addr, ma_cnt, ma_eaddr, mb_addr, mb_cnt, mb_eaddr;
  bit ma_err, mb_err;

  always #5 clk = ~clk;

  instr_assembler #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .req_valid(req_valid), .req_ready(a_req_ready),
    .req_opcode(req_opcode), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_funct3(req_funct3), .req_funct7(req_funct7), .req_imm(req_imm),
    .imem_we(a_imem_we), .imem_addr(a_imem_addr), .imem_wdata(a_imem_wdata),
    .imem_ready(imem_ready), .word_count(a_word_count), .err(a_err), .err_addr(a_err_addr)
  );

  instr_assembler #(.ADDR_W(2), .BASE_ADDR(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .req_valid(req_valid), .req_ready(b_req_ready),
    .req_opcode(req_opcode), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_funct3(req_funct3), .req_funct7(req_funct7), .req_imm(req_imm),
    .imem_we(b_imem_we), .imem_addr(b_imem_addr), .imem_wdata(b_imem_wdata),
    .imem_ready(imem_ready), .word_count(b_word_count), .err(b_err), .err_addr(b_err_addr)
  );

  function automatic void model_enc(input logic [6:0] op, input logic [2:0] f3,
                                    input logic [6:0] f7, input logic [4:0] rd,
                                    input logic [4:0] rs1, input logic [4:0] rs2,
                                    input int imm, output logic [31:0] w, output bit ok);
    logic [31:0] u;
    u = imm;
    w = 32'h0;
    ok = 1'b0;
    case (op)
      7'b0110011: begin w = {f7, rs2, rs1, f3, rd, op}; ok = 1'b1; end
      7'b0010011, 7'b0000011: begin
        w = {u[11:0], rs1, f3, rd, op}; ok = (imm >= -2048) && (imm <= 2047);
      end
      7'b0100011: begin
        w = {u[11:5], rs2, rs1, f3, u[4:0], op}; ok = (imm >= -2048) && (imm <= 2047);
      end
      7'b1100011: begin
        w = {u[12], u[10:5], rs2, rs1, f3, u[4:1], u[11], op};
        ok = (imm >= -4096) && (imm <= 4094) && (imm % 2 == 0);
      end
      default: ok = 1'b0;
    endcase
  endfunction

  function automatic void model_clear();
    ma_addr = 0; ma_cnt = 0; ma_err = 0; ma_eaddr = 0;
    mb_addr = 1; mb_cnt = 0; mb_err = 0; mb_eaddr = 0;
  endfunction

  task automatic drive_req(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input int imm);
    req_opcode = op; req_funct3 = f3; req_funct7 = f7;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    req_valid = 1'b1;
  endtask

  // One full transaction checked cycle by cycle; stall = cycles imem_ready is held low.
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input int imm, input int stall, output logic [31:0] obs);
    logic [31:0] w;
    bit ok;
    model_enc(op, f3, f7, rd, rs1, rs2, imm, w, ok);
    @(negedge clk);
    vectors++;
    if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_ready: got %b/%b want 1/1", a_req_ready, b_req_ready);
    end
    drive_req(op, f3, f7, rd, rs1, rs2, imm);
    imem_ready = (stall == 0);
    @(negedge clk);
    req_valid = 1'b0;
    vectors++;
    if (a_req_ready !== 1'b0 || b_req_ready !== 1'b0 || a_imem_we !== 1'b0 || b_imem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL encode_cycle: ready %b/%b we %b/%b want 0", a_req_ready, b_req_ready, a_imem_we, b_imem_we);
    end
    @(negedge clk);
    obs = a_imem_wdata;
    if (ok) begin
      for (int k = 0; k <= stall; k++) begin
        imem_ready = (k == stall);
        vectors++;
        if (a_imem_we !== 1'b1 || b_imem_we !== 1'b1 || a_imem_wdata !== w || b_imem_wdata !== w ||
            a_imem_addr !== 8'(ma_addr) || b_imem_addr !== 2'(mb_addr) ||
            a_req_ready !== 1'b0 || b_req_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL write op=%b imm=%0d k=%0d: we %b/%b data %h/%h addr %0d/%0d ready %b/%b want data %h addr %0d/%0d",
                   op, imm, k, a_imem_we, b_imem_we, a_imem_wdata, b_imem_wdata, a_imem_addr, b_imem_addr,
                   a_req_ready, b_req_ready, w, ma_addr, mb_addr);
        end
        @(negedge clk);
      end
      ma_addr = (ma_addr + 1) % 256;
      mb_addr = (mb_addr + 1) % 4;
      ma_cnt = (ma_cnt < 511) ? ma_cnt + 1 : 511;
      mb_cnt = (mb_cnt < 7) ? mb_cnt + 1 : 7;
      vectors++;
      if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1 || a_imem_we !== 1'b0 || b_imem_we !== 1'b0 ||
          a_word_count !== 9'(ma_cnt) || b_word_count !== 3'(mb_cnt) ||
          a_imem_addr !== 8'(ma_addr) || b_imem_addr !== 2'(mb_addr)) begin
        miscompares++;
        $display("FAIL after_write: ready %b/%b we %b/%b cnt %0d/%0d addr %0d/%0d want cnt %0d/%0d addr %0d/%0d",
                 a_req_ready, b_req_ready, a_imem_we, b_imem_we, a_word_count, b_word_count,
                 a_imem_addr, b_imem_addr, ma_cnt, mb_cnt, ma_addr, mb_addr);
      end
    end else begin
      if (!ma_err) begin ma_err = 1'b1; ma_eaddr = ma_addr; end
      if (!mb_err) begin mb_err = 1'b1; mb_eaddr = mb_addr; end
      vectors++;
      if (a_err !== 1'b1 || b_err !== 1'b1 || a_err_addr !== 8'(ma_eaddr) || b_err_addr !== 2'(mb_eaddr) ||
          a_imem_we !== 1'b0 || b_imem_we !== 1'b0 || a_req_ready !== 1'b1 || b_req_ready !== 1'b1 ||
          a_imem_addr !== 8'(ma_addr) || b_imem_addr !== 2'(mb_addr) ||
          a_word_count !== 9'(ma_cnt) || b_word_count !== 3'(mb_cnt)) begin
        miscompares++;
        $display("FAIL reject op=%b imm=%0d: err %b/%b eaddr %0d/%0d we %b/%b ready %b/%b addr %0d/%0d cnt %0d/%0d want eaddr %0d/%0d",
                 op, imm, a_err, b_err, a_err_addr, b_err_addr, a_imem_we, b_imem_we, a_req_ready, b_req_ready,
                 a_imem_addr, b_imem_addr, a_word_count, b_word_count, ma_eaddr, mb_eaddr);
      end
    end
    imem_ready = 1'b1;
  endtask

  task automatic check_cleared(input string name, input logic [31:0] want_wdata, input bit chk_wdata);
    vectors++;
    if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1 || a_imem_we !== 1'b0 || b_imem_we !== 1'b0 ||
        a_imem_addr !== 8'd0 || b_imem_addr !== 2'd1 || a_word_count !== 9'd0 || b_word_count !== 3'd0 ||
        a_err !== 1'b0 || b_err !== 1'b0 || a_err_addr !== 8'd0 || b_err_addr !== 2'd0 ||
        (chk_wdata && (a_imem_wdata !== want_wdata || b_imem_wdata !== want_wdata))) begin
      miscompares++;
      $display("FAIL %s: ready %b/%b we %b/%b addr %0d/%0d cnt %0d/%0d err %b/%b eaddr %0d/%0d wdata %h want ready 1 we 0 addr 0/1 cnt 0 err 0 eaddr 0",
               name, a_req_ready, b_req_ready, a_imem_we, b_imem_we, a_imem_addr, b_imem_addr,
               a_word_count, b_word_count, a_err, b_err, a_err_addr, b_err_addr, a_imem_wdata);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    check_cleared("reset_values", 32'h0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_errors();
    logic [31:0] obs;
    send(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 2048, 0, obs);
    send(7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 3, 0, obs);
    send(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 5, 0, obs);
    vectors++;
    if (obs !== 32'h00510093 || a_word_count !== 9'd1 || a_err_addr !== 8'd0) begin
      miscompares++;
      $display("FAIL addi_after_err: word %h cnt %0d eaddr %0d want 00510093 1 0", obs, a_word_count, a_err_addr);
    end
  endtask

  task automatic test_store_branch();
    logic [31:0] obs;
    send(7'b0100011, 3'd2, 7'd0, 5'd0, 5'd2, 5'd5, -4, 0, obs);
    vectors++;
    if (obs !== 32'hFE512E23) begin
      miscompares++;
      $display("FAIL sw_word: got %h want FE512E23", obs);
    end
    send(7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -8, 0, obs);
    vectors++;
    if (obs !== 32'hFE208CE3 || a_imem_addr !== 8'd3) begin
      miscompares++;
      $display("FAIL beq_word: got %h addr %0d want FE208CE3 3", obs, a_imem_addr);
    end
  endtask

  task automatic test_stall();
    logic [31:0] obs;
    send(7'b0110011, 3'd0, 7'b0100000, 5'd3, 5'd4, 5'd5, 0, 3, obs);
  endtask

  task automatic test_clr();
    // clr while a write is stalled
    @(negedge clk);
    drive_req(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 7);
    imem_ready = 1'b0;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (a_imem_we !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_setup_we: got %b want 1", a_imem_we);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
    check_cleared("clr_mid_write", 32'h0, 1'b0);
    // clr in the very cycle a write is accepted: not counted
    @(negedge clk);
    drive_req(7'b0010011, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 9);
    @(negedge clk); req_valid = 1'b0;
    imem_ready = 1'b1;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_cleared("clr_on_accept", 32'h0, 1'b0);
  endtask

  task automatic test_wrap();
    logic [31:0] obs;
    for (int i = 0; i < 5; i++)
      send(7'b0000011, 3'd2, 7'd0, 5'(i + 1), 5'd2, 5'd0, 4 * i, 0, obs);
    vectors++;
    if (b_word_count !== 3'd5 || b_imem_addr !== 2'd2 || a_word_count !== 9'd5) begin
      miscompares++;
      $display("FAIL wrap_count: b cnt %0d addr %0d a cnt %0d want 5 2 5", b_word_count, b_imem_addr, a_word_count);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [6];
    int edges [8];
    logic [31:0] obs;
    int imm;
    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
    ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
    edges[0] = -2048; edges[1] = -2049; edges[2] = 2047; edges[3] = 2048;
    edges[4] = -4096; edges[5] = -4098; edges[6] = 4094; edges[7] = 4095;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 8) imm = edges[$urandom_range(0, 7)];
      else imm = int'($urandom_range(0, 8191)) - 4096;
      send(ops[$urandom_range(0, 5)], 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), imm, int'($urandom_range(0, 2)), obs);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive_req(7'b0110011, 3'd7, 7'd0, 5'd9, 5'd8, 5'd7, 0);
    imem_ready = 1'b0;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("async_reset", 32'h0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    imem_ready = 1'b1;
    model_clear();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_errors();
    test_store_branch();
    test_stall();
    test_clr();
    test_wrap();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
